// File: rtl/eth_phy_10g_rx_descrambler.sv
// 10GBASE-R receive descrambler (G(x) = 1 + x^39 + x^58) with lock-qualified output
// and sync-header BER monitor (hi_ber) plus a saturating bad-header counter.
module eth_phy_10g_rx_descrambler #(
   parameter int DATA_WIDTH = 64,
   parameter int HDR_WIDTH  = 2,
   parameter int BER_WINDOW = 19531,
   parameter int BER_THRESH = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [HDR_WIDTH-1:0]  i_serdes_rx_hdr_align,
   input  logic [DATA_WIDTH-1:0] i_serdes_rx_data_align,
   input  logic                  i_rx_block_lock,
   output logic [HDR_WIDTH-1:0]  o_rx_hdr,
   output logic [DATA_WIDTH-1:0] o_rx_data,
   output logic                  o_rx_valid,
   output logic                  o_rx_high_ber,
   output logic [15:0]           o_rx_bad_hdr_cnt
);

   localparam int SCR_W = 58;
   localparam int WIN_W = $clog2(BER_WINDOW);
   localparam int ERR_W = $clog2(BER_THRESH + 1);
   localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(BER_WINDOW - 1);
   localparam logic [ERR_W-1:0] THRESH_V = ERR_W'(BER_THRESH);

   logic [SCR_W-1:0]            r_scr_state;
   logic [HDR_WIDTH-1:0]        r_rx_hdr;
   logic [DATA_WIDTH-1:0]       r_rx_data;
   logic                        r_lock_d;
   logic                        r_rx_valid;
   logic [WIN_W-1:0]            r_win_cnt;
   logic [ERR_W-1:0]            r_err_cnt;
   logic                        r_high_ber;
   logic [15:0]                 r_bad_cnt;

   logic [DATA_WIDTH+SCR_W-1:0] w_ext;
   logic [DATA_WIDTH-1:0]       w_descr;
   logic                        w_hdr_bad;
   logic [ERR_W-1:0]            w_err_next;
   logic                        w_win_end;
   logic                        w_err_hit;

   // Line history: bit j of w_ext is the bit received (58 - j) positions before
   // the current block's bit 0; taps at 39 and 58 bits back.
   always_comb begin
      w_ext   = {i_serdes_rx_data_align, r_scr_state};
      w_descr = '0;
      for (int i = 0; i < DATA_WIDTH; i++) begin
         w_descr[i] = w_ext[SCR_W + i] ^ w_ext[19 + i] ^ w_ext[i];
      end
   end

   always_comb begin
      w_hdr_bad  = (i_serdes_rx_hdr_align == 2'b00) || (i_serdes_rx_hdr_align == 2'b11);
      w_err_next = r_err_cnt;
      if (w_hdr_bad && (r_err_cnt != THRESH_V)) begin
         w_err_next = r_err_cnt + ERR_W'(1);
      end
      w_win_end  = (r_win_cnt == WIN_LAST);
      w_err_hit  = (w_err_next == THRESH_V);
   end

   // Descrambler runs on every block so its state tracks the line even unlocked.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_scr_state <= '0;
         r_rx_hdr    <= '0;
         r_rx_data   <= '0;
         r_lock_d    <= 1'b0;
         r_rx_valid  <= 1'b0;
      end else begin
         r_scr_state <= i_serdes_rx_data_align[DATA_WIDTH-1 -: SCR_W];
         r_rx_hdr    <= i_serdes_rx_hdr_align;
         r_rx_data   <= w_descr;
         r_lock_d    <= i_rx_block_lock;
         r_rx_valid  <= i_rx_block_lock & r_lock_d;
      end
   end

   // An invalid header in the last window cycle is folded into the closing window.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_win_cnt  <= '0;
         r_err_cnt  <= '0;
         r_high_ber <= 1'b0;
      end else if (!i_rx_block_lock) begin
         r_win_cnt  <= '0;
         r_err_cnt  <= '0;
         r_high_ber <= 1'b0;
      end else if (w_win_end) begin
         r_win_cnt  <= '0;
         r_err_cnt  <= '0;
         r_high_ber <= w_err_hit;
      end else begin
         r_win_cnt  <= r_win_cnt + WIN_W'(1);
         r_err_cnt  <= w_err_next;
         if (w_err_hit) begin
            r_high_ber <= 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_bad_cnt <= '0;
      end else if (i_rx_block_lock && w_hdr_bad && (r_bad_cnt != 16'hFFFF)) begin
         r_bad_cnt <= r_bad_cnt + 16'd1;
      end
   end

   // Valid-only stream: no backpressure, each asserted o_rx_valid is one block.
   assign o_rx_hdr         = r_rx_hdr;
   assign o_rx_data        = r_rx_data;
   assign o_rx_valid       = r_rx_valid;
   assign o_rx_high_ber    = r_high_ber;
   assign o_rx_bad_hdr_cnt = r_bad_cnt;

endmodule

// File: tb/tb_eth_phy_10g_rx_descrambler.sv
// Bench for eth_phy_10g_rx_descrambler: serial bit-history reference model,
// vector table, directed BER/lock/reset sequences and randomized traffic.
module tb_eth_phy_10g_rx_descrambler;

   localparam int W = 100;
   localparam int T = 16;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [1:0]  i_hdr = '0;
   logic [63:0] i_data = '0;
   logic        i_lock = 1'b0;
   logic [1:0]  o_rx_hdr;
   logic [63:0] o_rx_data;
   logic        o_rx_valid;
   logic        o_rx_high_ber;
   logic [15:0] o_rx_bad_hdr_cnt;

   int n_checks = 0;
   int n_fail   = 0;

   eth_phy_10g_rx_descrambler #(
      .DATA_WIDTH(64), .HDR_WIDTH(2), .BER_WINDOW(W), .BER_THRESH(T)
   ) dut (
      .clk                    (clk),
      .rst                    (rst),
      .i_serdes_rx_hdr_align  (i_hdr),
      .i_serdes_rx_data_align (i_data),
      .i_rx_block_lock        (i_lock),
      .o_rx_hdr               (o_rx_hdr),
      .o_rx_data              (o_rx_data),
      .o_rx_valid             (o_rx_valid),
      .o_rx_high_ber          (o_rx_high_ber),
      .o_rx_bad_hdr_cnt       (o_rx_bad_hdr_cnt)
   );

   // clock / watchdog
   always #5 clk = ~clk;

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation time limit reached, got no finish expected finish");
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail + 1);
      $fatal(1, "watchdog");
   end

   // reference model: serial line-bit histories, oldest bit at index 0
   bit   rx_hist[$];
   bit   tx_hist[$];
   bit   m_prev_lock;
   int   m_win, m_err, m_bad;
   bit   m_hiber;
   logic [83:0] exp_q[$];

   function automatic void model_reset();
      rx_hist.delete();
      tx_hist.delete();
      for (int i = 0; i < 58; i++) begin
         rx_hist.push_back(1'b0);
         tx_hist.push_back(1'b0);
      end
      m_prev_lock = 1'b0;
      m_win = 0; m_err = 0; m_bad = 0; m_hiber = 1'b0;
      exp_q.delete();
   endfunction

   function automatic logic [63:0] scramble(input logic [63:0] p);
      logic [63:0] s;
      bit b;
      for (int i = 0; i < 64; i++) begin
         b = p[i] ^ tx_hist[19] ^ tx_hist[0];
         s[i] = b;
         tx_hist.push_back(b);
         void'(tx_hist.pop_front());
      end
      return s;
   endfunction

   function automatic void model_step(input logic [1:0] hdr, input logic [63:0] d, input logic lock);
      logic [63:0] o;
      bit bad;
      bit v;
      for (int i = 0; i < 64; i++) begin
         o[i] = d[i] ^ rx_hist[19] ^ rx_hist[0];
         rx_hist.push_back(d[i]);
         void'(rx_hist.pop_front());
      end
      bad = (hdr == 2'b00) || (hdr == 2'b11);
      v = lock && m_prev_lock;
      m_prev_lock = lock;
      if (!lock) begin
         m_win = 0; m_err = 0; m_hiber = 1'b0;
      end else begin
         if (bad && m_err < T) m_err++;
         if (bad && m_bad < 65535) m_bad++;
         if (m_win == W - 1) begin
            m_hiber = (m_err >= T);
            m_err = 0;
            m_win = 0;
         end else begin
            m_win++;
            if (m_err >= T) m_hiber = 1'b1;
         end
      end
      exp_q.push_back({v, m_hiber, 16'(m_bad), hdr, o});
   endfunction

   // scoreboard
   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         if (n_fail <= 40) $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
      end
   endtask

   // driver: called at a falling edge, returns at the next falling edge
   task automatic cycle(input logic [1:0] hdr, input logic [63:0] d, input logic lock);
      logic [83:0] e;
      i_hdr = hdr; i_data = d; i_lock = lock;
      @(posedge clk);
      model_step(hdr, d, lock);
      @(negedge clk);
      e = exp_q.pop_front();
      chk("data",   o_rx_data,                e[63:0]);
      chk("hdr",    64'(o_rx_hdr),            64'(e[65:64]));
      chk("badcnt", 64'(o_rx_bad_hdr_cnt),    64'(e[81:66]));
      chk("hiber",  64'(o_rx_high_ber),       64'(e[82]));
      chk("valid",  64'(o_rx_valid),          64'(e[83]));
   endtask

   function automatic logic [63:0] rnd64();
      return {$urandom(), $urandom()};
   endfunction

   function automatic logic [1:0] bad_hdr();
      return ($urandom_range(0, 1) == 0) ? 2'b00 : 2'b11;
   endfunction

   function automatic logic [1:0] good_hdr();
      return ($urandom_range(0, 1) == 0) ? 2'b01 : 2'b10;
   endfunction

   typedef struct {
      logic [1:0]  hdr;
      logic [63:0] data;
      logic        lock;
      logic        exp_valid;
      logic        exp_hiber;
      logic [15:0] exp_bad;
   } vec_t;

   vec_t vecs[8];

   initial begin
      vecs[0] = '{2'b11, 64'hFFFFFFFF7FFFFFFF, 1'b0, 1'b0, 1'b0, 16'd0};
      vecs[1] = '{2'b11, 64'hFFFFFFFF7FFFFFFF, 1'b0, 1'b0, 1'b0, 16'd0};
      vecs[2] = '{2'b11, 64'hFFFFFFFF7FFFFFFF, 1'b0, 1'b0, 1'b0, 16'd0};
      vecs[3] = '{2'b11, 64'hFFFFFFFF7FFFFFFF, 1'b0, 1'b0, 1'b0, 16'd0};
      vecs[4] = '{2'b10, 64'h0123456789ABCDEF, 1'b1, 1'b0, 1'b0, 16'd0};
      vecs[5] = '{2'b01, 64'hFEDCBA9876543210, 1'b1, 1'b1, 1'b0, 16'd0};
      vecs[6] = '{2'b00, 64'hA5A5A5A5A5A5A5A5, 1'b1, 1'b1, 1'b0, 16'd1};
      vecs[7] = '{2'b11, 64'h5A5A5A5A5A5A5A5A, 1'b0, 1'b0, 1'b0, 16'd1};

      // reset state
      model_reset();
      repeat (3) @(negedge clk);
      chk("rst_data",  o_rx_data,              64'd0);
      chk("rst_hdr",   64'(o_rx_hdr),          64'd0);
      chk("rst_valid", 64'(o_rx_valid),        64'd0);
      chk("rst_hiber", 64'(o_rx_high_ber),     64'd0);
      chk("rst_bad",   64'(o_rx_bad_hdr_cnt),  64'd0);
      rst = 1'b0;

      // scrambled idle stream
      for (int k = 1; k <= 8; k++) begin
         cycle(2'b10, scramble(64'h000000000000001E), 1'b1);
         if (k == 1) chk("idle_valid_c1", 64'(o_rx_valid), 64'd0);
         if (k >= 2) begin
            chk("idle_valid", 64'(o_rx_valid), 64'd1);
            chk("idle_data",  o_rx_data, 64'h000000000000001E);
         end
      end
      chk("idle_bad", 64'(o_rx_bad_hdr_cnt), 64'd0);

      // vector table: unlocked aligner-style input, lock rise, header counting
      for (int i = 0; i < 8; i++) begin
         cycle(vecs[i].hdr, vecs[i].data, vecs[i].lock);
         chk("tbl_valid", 64'(o_rx_valid),       64'(vecs[i].exp_valid));
         chk("tbl_hiber", 64'(o_rx_high_ber),    64'(vecs[i].exp_hiber));
         chk("tbl_bad",   64'(o_rx_bad_hdr_cnt), 64'(vecs[i].exp_bad));
      end

      // randomized traffic with occasional lock drops
      for (int n = 0; n < 3000; n++) begin
         logic lk;
         logic [1:0] h;
         lk = ($urandom_range(0, 99) != 0);
         h  = ($urandom_range(0, 5) == 0) ? bad_hdr() : good_hdr();
         cycle(h, rnd64(), lk);
      end

      // 15 invalid headers in a window, then 16, then a clean window
      cycle(2'b10, rnd64(), 1'b0);
      for (int p = 0; p < W; p++) cycle((p >= 10 && p < 25) ? bad_hdr() : good_hdr(), rnd64(), 1'b1);
      chk("hb_15_in_window", 64'(o_rx_high_ber), 64'd0);
      for (int p = 0; p < W; p++) begin
         cycle((p < 16) ? bad_hdr() : good_hdr(), rnd64(), 1'b1);
         if (p == 14) chk("hb_before_16th", 64'(o_rx_high_ber), 64'd0);
         if (p == 15) chk("hb_after_16th",  64'(o_rx_high_ber), 64'd1);
      end
      chk("hb_held_window_end", 64'(o_rx_high_ber), 64'd1);
      for (int p = 0; p < W; p++) begin
         cycle(good_hdr(), rnd64(), 1'b1);
         if (p == W - 2) chk("hb_clean_before_end", 64'(o_rx_high_ber), 64'd1);
         if (p == W - 1) chk("hb_clean_at_end",     64'(o_rx_high_ber), 64'd0);
      end

      // 16th invalid header on the last window cycle
      for (int p = 0; p < W; p++) begin
         cycle((p >= W - 16) ? bad_hdr() : good_hdr(), rnd64(), 1'b1);
         if (p == W - 2) chk("hb_last_before", 64'(o_rx_high_ber), 64'd0);
         if (p == W - 1) chk("hb_last_set",    64'(o_rx_high_ber), 64'd1);
      end
      for (int p = 0; p < W; p++) begin
         cycle((p < 15) ? bad_hdr() : good_hdr(), rnd64(), 1'b1);
         if (p == W - 1) chk("hb_new_window_fresh", 64'(o_rx_high_ber), 64'd0);
      end

      // one-cycle lock drop while hi_ber is set
      for (int p = 0; p < 20; p++) cycle((p < 16) ? bad_hdr() : good_hdr(), rnd64(), 1'b1);
      chk("hb_pre_drop", 64'(o_rx_high_ber), 64'd1);
      cycle(2'b11, rnd64(), 1'b0);
      chk("drop_hiber", 64'(o_rx_high_ber), 64'd0);
      chk("drop_valid", 64'(o_rx_valid),    64'd0);
      chk("drop_bad",   64'(o_rx_bad_hdr_cnt), 64'(m_bad));
      cycle(good_hdr(), rnd64(), 1'b1);
      chk("relock_valid_c1", 64'(o_rx_valid), 64'd0);
      cycle(good_hdr(), rnd64(), 1'b1);
      chk("relock_valid_c2", 64'(o_rx_valid), 64'd1);

      // saturation of the bad-header counter
      for (int n = 0; n < 70000; n++) cycle(bad_hdr(), rnd64(), 1'b1);
      chk("sat_bad",   64'(o_rx_bad_hdr_cnt), 64'h000000000000FFFF);
      chk("sat_hiber", 64'(o_rx_high_ber),    64'd1);

      // asynchronous reset mid-stream
      rst = 1'b1;
      #1;
      chk("arst_data",  o_rx_data,             64'd0);
      chk("arst_hdr",   64'(o_rx_hdr),         64'd0);
      chk("arst_valid", 64'(o_rx_valid),       64'd0);
      chk("arst_hiber", 64'(o_rx_high_ber),    64'd0);
      chk("arst_bad",   64'(o_rx_bad_hdr_cnt), 64'd0);
      model_reset();
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      cycle(2'b10, rnd64(), 1'b1);
      chk("post_rst_valid_c1", 64'(o_rx_valid), 64'd0);
      cycle(2'b01, rnd64(), 1'b1);
      chk("post_rst_valid_c2", 64'(o_rx_valid), 64'd1);
      for (int n = 0; n < 8; n++) cycle(good_hdr(), rnd64(), 1'b1);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
